// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use and mul/div interlocks, branch flush, stall counter
module hazard_ctrl #(
    parameter int REG_W         = 5,
    parameter int LOAD_LAT      = 1,
    parameter int MULDIV_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ifid_hilo_use,
    input  logic             muldiv_start,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // Counter widths; a single bit is kept even when the count is degenerate.
    localparam int LD_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int MD_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        LOAD_STALL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LD_W-1:0]    ld_cnt_q, ld_cnt_d;
    logic [MD_W-1:0]    md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic match;
    logic load_hz;
    logic busy_raw;
    logic md_hz;
    logic stall;

    // Hazard detection is purely combinational so the first stall cycle costs no latency.
    always_comb begin
        match    = idex_memread && (idex_rd != '0) &&
                   ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));
        load_hz  = ((state_q == IDLE) && match) || (state_q == LOAD_STALL);
        busy_raw = muldiv_start || (md_cnt_q != '0);
        md_hz    = busy_raw && ifid_hilo_use;
        stall    = (load_hz || md_hz) && !branch_taken;
    end

    // Load-use FSM: the first stall cycle is the detection cycle, LOAD_STALL supplies the rest.
    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        if (branch_taken) begin
            // The stalled ID instruction is wrong-path, so any pending load stall is dropped.
            state_d  = IDLE;
            ld_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match && (LOAD_LAT > 1)) begin
                        state_d  = LOAD_STALL;
                        ld_cnt_d = LD_W'(LOAD_LAT - 1);
                    end
                end
                LOAD_STALL: begin
                    if (ld_cnt_q == LD_W'(1)) begin
                        state_d  = IDLE;
                        ld_cnt_d = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q - LD_W'(1);
                    end
                end
                default: begin
                    state_d  = IDLE;
                    ld_cnt_d = '0;
                end
            endcase
        end
    end

    // Mul/div busy window: the issue cycle plus MULDIV_CYCLES-1 counted-down cycles.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (muldiv_start) begin
            md_cnt_d = MD_W'(MULDIV_CYCLES - 1);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end
    end

    // Saturating count of stall cycles; flush cycles never count because stall excludes them.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ld_cnt_q       <= '0;
            md_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            ld_cnt_q       <= ld_cnt_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Pipeline control: reset forces pass-through, branch flush beats stall, stall beats pass.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        muldiv_busy = 1'b0;
        if (!reset) begin
            muldiv_busy = busy_raw;
            if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;

    localparam int REG_W  = 5;
    localparam int LL     = 3;
    localparam int MDC    = 4;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             idex_memread = 1'b0;
    logic [REG_W-1:0] idex_rd = '0;
    logic [REG_W-1:0] ifid_rs = '0;
    logic [REG_W-1:0] ifid_rt = '0;
    logic             ifid_uses_rt = 1'b0;
    logic             ifid_hilo_use = 1'b0;
    logic             muldiv_start = 1'b0;
    logic             branch_taken = 1'b0;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy;
    logic [CW-1:0]    stall_cycles;
    logic [4:0]       outs;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: remaining stall / busy cycles after the current one
    int   ld_rem = 0;
    int   md_rem = 0;
    int   cnt_m  = 0;
    bit   m_match;
    bit   exp_stall;
    logic [4:0] exp_outs;
    int   exp_cnt;

    always #5 clk = ~clk;

    assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy};

    hazard_ctrl #(
        .REG_W(REG_W), .LOAD_LAT(LL), .MULDIV_CYCLES(MDC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .ifid_hilo_use(ifid_hilo_use), .muldiv_start(muldiv_start),
        .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .muldiv_busy(muldiv_busy),
        .stall_cycles(stall_cycles)
    );

    task automatic drive(input bit mr, input int rd, input int rs, input int rt,
                         input bit urt, input bit hilo, input bit ms, input bit br);
        idex_memread  = mr;
        idex_rd       = REG_W'(rd);
        ifid_rs       = REG_W'(rs);
        ifid_rt       = REG_W'(rt);
        ifid_uses_rt  = urt;
        ifid_hilo_use = hilo;
        muldiv_start  = ms;
        branch_taken  = br;
    endtask

    // expected outputs for the current cycle, sampled at the falling edge
    task automatic eval_model();
        bit busy;
        @(negedge clk);
        m_match = idex_memread && (idex_rd != 0) &&
                  ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));
        busy = muldiv_start || (md_rem > 0);
        exp_stall = ((ld_rem > 0) || m_match || (busy && ifid_hilo_use)) && !branch_taken;
        if (reset)             exp_outs = 5'b11000;
        else if (branch_taken) exp_outs = {4'b1111, busy};
        else if (exp_stall)    exp_outs = {4'b0001, busy};
        else                   exp_outs = {4'b1100, busy};
        exp_cnt = cnt_m;
    endtask

    // advance model through the rising edge, then leave #1 for input changes
    task automatic commit();
        @(posedge clk);
        if (reset) begin
            ld_rem = 0; md_rem = 0; cnt_m = 0;
        end else begin
            if (branch_taken)    ld_rem = 0;
            else if (ld_rem > 0) ld_rem = ld_rem - 1;
            else if (m_match)    ld_rem = LL - 1;
            if (muldiv_start)    md_rem = MDC - 1;
            else if (md_rem > 0) md_rem = md_rem - 1;
            if (exp_stall && cnt_m < CMAX) cnt_m = cnt_m + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        eval_model();
        commit();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 5, 5, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            eval_model();
            n_checks++;
            if (outs !== 5'b11000) begin
                n_fail++;
                $display("FAIL reset_outs cyc %0d: got %b expected 11000", i, outs);
            end
            if (i > 0) begin
                n_checks++;
                if (stall_cycles !== CW'(0)) begin
                    n_fail++;
                    $display("FAIL reset_cnt cyc %0d: got %0d expected 0", i, stall_cycles);
                end
            end
            commit();
        end
        reset = 1'b0;
    endtask

    task automatic test_load_basic();
        int stalls = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(1, 5, 5, 0, 0, 0, 0, 0);
            else        drive(0, 5, 5, 0, 0, 0, 0, 0);
            eval_model();
            if (idex_bubble && !ifid_flush) stalls++;
            n_checks++;
            if (outs !== exp_outs) begin
                n_fail++;
                $display("FAIL load_basic cyc %0d: got %b expected %b", i, outs, exp_outs);
            end
            commit();
        end
        n_checks++;
        if (stalls != LL) begin
            n_fail++;
            $display("FAIL load_len: got %0d stall cycles expected %0d", stalls, LL);
        end
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        eval_model();
        n_checks++;
        if (outs !== 5'b11000) begin
            n_fail++;
            $display("FAIL reg_zero: got %b expected 11000", outs);
        end
        n_checks++;
        if (stall_cycles !== CW'(LL)) begin
            n_fail++;
            $display("FAIL load_cnt: got %0d expected %0d", stall_cycles, LL);
        end
        commit();
    endtask

    task automatic test_uses_rt();
        do_reset();
        drive(1, 7, 3, 7, 0, 0, 0, 0);
        eval_model();
        n_checks++;
        if (outs !== 5'b11000) begin
            n_fail++;
            $display("FAIL rt_unused: got %b expected 11000", outs);
        end
        commit();
        drive(1, 7, 3, 7, 1, 0, 0, 0);
        eval_model();
        n_checks++;
        if (outs !== 5'b00010) begin
            n_fail++;
            $display("FAIL rt_used: got %b expected 00010", outs);
        end
        commit();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LL; i++) begin eval_model(); commit(); end
    endtask

    task automatic test_muldiv();
        do_reset();
        for (int i = 0; i <= MDC + 1; i++) begin
            drive(0, 0, 0, 0, 0, 1, (i == 0), 0);
            eval_model();
            n_checks++;
            if (outs !== ((i < MDC) ? 5'b00011 : 5'b11000) || outs !== exp_outs) begin
                n_fail++;
                $display("FAIL muldiv cyc %0d: got %b expected %b", i, outs, exp_outs);
            end
            commit();
        end
    endtask

    task automatic test_branch_flush();
        do_reset();
        drive(1, 9, 9, 0, 0, 0, 0, 0);
        eval_model(); commit();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        eval_model();
        n_checks++;
        if (outs !== 5'b11110) begin
            n_fail++;
            $display("FAIL branch_flush: got %b expected 11110", outs);
        end
        commit();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        eval_model();
        n_checks++;
        if (outs !== 5'b11000) begin
            n_fail++;
            $display("FAIL after_flush: got %b expected 11000", outs);
        end
        n_checks++;
        if (stall_cycles !== CW'(1)) begin
            n_fail++;
            $display("FAIL flush_cnt: got %0d expected 1", stall_cycles);
        end
        commit();
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 4, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin eval_model(); commit(); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LL; i++) begin eval_model(); commit(); end
        eval_model();
        n_checks++;
        if (stall_cycles !== CW'(CMAX)) begin
            n_fail++;
            $display("FAIL saturate: got %0d expected %0d", stall_cycles, CMAX);
        end
        commit();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 6, 6, 0, 0, 0, 0, 0);
        eval_model(); commit();
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        eval_model(); commit();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        eval_model();
        n_checks++;
        if (outs !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_mid_outs: got %b expected 11000", outs);
        end
        commit();
        reset = 1'b0;
        eval_model();
        n_checks++;
        if (outs !== 5'b11000 || stall_cycles !== CW'(0)) begin
            n_fail++;
            $display("FAIL reset_release: got %b cnt %0d expected 11000 cnt 0", outs, stall_cycles);
        end
        commit();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive(($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            eval_model();
            n_checks++;
            if (outs !== exp_outs) begin
                n_fail++;
                $display("FAIL random_outs cyc %0d: got %b expected %b", i, outs, exp_outs);
            end
            n_checks++;
            if (stall_cycles !== CW'(exp_cnt)) begin
                n_fail++;
                $display("FAIL random_cnt cyc %0d: got %0d expected %0d", i, stall_cycles, exp_cnt);
            end
            commit();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_uses_rt();
        test_muldiv();
        test_branch_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
